fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of control_unit.
- Holds the program counter and reads 16-bit instructions from instruction memory over a req/valid handshake.
- Presents each instruction on instr, which drives control_unit d_in, and gates control_unit with run until it reports done.
- Advances the PC per retired instruction; handles start/stop, a HALT encoding and memory timeout.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_timeout_ctr.sv | 47 ++++
 rtl/fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default HALT encoding and instruction-format codes shared with control_unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  localparam logic [15:0] HALT_INSTR_DEFAULT = 16'hFFFF;

  // Instruction-format field codes, kept in step with control_unit.
  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_M = 2'b11;

  // States in which the fetch stage owns the memory port or control_unit.
  function automatic logic is_busy_state(input fetch_state_e s);
    return (s == ST_REQ) || (s == ST_WAIT) || (s == ST_EXEC);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Loadable up-counter used to bound the wait for mem_valid. tc flags that the
// enabled increment taken this cycle lands on TIMEOUT.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over load, load over increment; stops at TIMEOUT.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CNT_W{1'b0}};
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != TERM_VAL)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && !clr && !load && (count_q == LAST_VAL);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads 16-bit instructions over a
// req/valid handshake and holds each one for control_unit while run is high.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] HALT_INSTR = HALT_INSTR_DEFAULT,
  parameter int                TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] instr,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [15:0]       instr_count_q, instr_count_d;
  logic              stop_pending_q, stop_pending_d;
  logic              timeout_err_q, timeout_err_d;
  logic              mem_req_q, mem_req_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              ctr_clr, ctr_en, ctr_tc;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (ctr_clr),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .en       (ctr_en),
    .tc       (ctr_tc)
  );

  // Next-state, datapath updates and output decode of the fetch sequencer.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_count_d  = instr_count_q;
    stop_pending_d = stop_pending_q;
    timeout_err_d  = timeout_err_q;
    ctr_clr        = 1'b0;
    ctr_en         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d        = ST_REQ;
          pc_d           = {ADDR_W{1'b0}};
          instr_count_d  = 16'd0;
          timeout_err_d  = 1'b0;
          stop_pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        ctr_clr = 1'b1;
        if (stop) begin
          stop_pending_d = 1'b1;
        end else begin
          stop_pending_d = stop_pending_q;
        end
      end
      ST_WAIT: begin
        if (stop) begin
          stop_pending_d = 1'b1;
        end else begin
          stop_pending_d = stop_pending_q;
        end
        if (mem_valid) begin
          instr_d = mem_rdata;
          if (stop_pending_q) begin
            // Fetched word is dropped; the PC still points at it.
            state_d        = ST_IDLE;
            stop_pending_d = 1'b0;
          end else if (mem_rdata == HALT_INSTR) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          ctr_en = 1'b1;
          if (ctr_tc) begin
            timeout_err_d = 1'b1;
            state_d       = ST_HALTED;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_EXEC: begin
        if (stop) begin
          stop_pending_d = 1'b1;
        end else begin
          stop_pending_d = stop_pending_q;
        end
        if (done) begin
          pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (instr_count_q != 16'hFFFF) begin
            instr_count_d = instr_count_q + 16'd1;
          end else begin
            instr_count_d = instr_count_q;
          end
          // A stop arriving together with done still ends at this boundary.
          if (stop_pending_q || stop) begin
            state_d        = ST_IDLE;
            stop_pending_d = 1'b0;
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_d        = ST_REQ;
          pc_d           = {ADDR_W{1'b0}};
          instr_count_d  = 16'd0;
          timeout_err_d  = 1'b0;
          stop_pending_d = 1'b0;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    mem_req_d = (state_d == ST_REQ);
    run_d     = (state_d == ST_EXEC);
    busy_d    = is_busy_state(state_d);
    halted_d  = (state_d == ST_HALTED);
  end

  // Sequencer state, datapath and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      pc_q           <= {ADDR_W{1'b0}};
      instr_q        <= {DATA_W{1'b0}};
      instr_count_q  <= 16'd0;
      stop_pending_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      mem_req_q      <= 1'b0;
      run_q          <= 1'b0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      instr_count_q  <= instr_count_d;
      stop_pending_q <= stop_pending_d;
      timeout_err_q  <= timeout_err_d;
      mem_req_q      <= mem_req_d;
      run_q          <= run_d;
      busy_q         <= busy_d;
      halted_q       <= halted_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign run         = run_q;
  assign pc          = pc_q;
  assign instr_count = instr_count_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes the expected memory
// requests and instruction issues; a monitor pops and compares them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_valid = 1'b0;
  logic [15:0] instr;
  logic        run;
  logic        done = 1'b0;
  logic [7:0]  pc;
  logic [15:0] instr_count;
  logic        busy;
  logic        halted;
  logic        timeout_err;

  fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .instr(instr), .run(run), .done(done),
    .pc(pc), .instr_count(instr_count), .busy(busy), .halted(halted),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_exec;
    logic [15:0] instr;
    logic [7:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          req_seen = 0;
  logic [15:0] mem [256];
  bit          mem_en = 1'b1;
  bit          done_force = 1'b0;
  bit          pend = 1'b0;
  logic [7:0]  pend_addr = 8'h00;
  int          run_cnt = 0;
  logic        run_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_req(input logic [7:0] a);
    exp_t e;
    e.is_exec = 1'b0; e.instr = 16'h0000; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic push_exec(input logic [15:0] i, input logic [7:0] a);
    exp_t e;
    e.is_exec = 1'b1; e.instr = i; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Instruction memory: answers each request with one cycle of latency.
  initial begin
    forever begin
      @(negedge clk);
      mem_valid = pend && mem_en;
      mem_rdata = pend ? mem[pend_addr] : 16'h0000;
      pend      = mem_req;
      pend_addr = mem_addr;
    end
  end

  // control_unit stand-in: done on the fourth run cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (run) run_cnt++;
      else run_cnt = 0;
      done = (run && run_cnt == 4) || done_force;
    end
  end

  // Monitor: compares each memory request and each instruction issue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        req_seen++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_req: got addr %0h expected none", mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("req_kind", {31'd0, e.is_exec}, 32'd0);
          check("req_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        end
      end
      if (run && !run_prev) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_exec: got instr %0h expected none", instr);
        end else begin
          e = exp_q.pop_front();
          check("exec_kind", {31'd0, e.is_exec}, 32'd1);
          check("exec_instr", {16'd0, instr}, {16'd0, e.instr});
          check("exec_pc", {24'd0, pc}, {24'd0, e.addr});
        end
      end
      if (run) check("no_run_on_halt", {31'd0, (instr == 16'hFFFF)}, 32'd0);
      run_prev = run;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int wcnt;
    for (int a = 0; a < 256; a++) mem[a] = 16'h2000 + 16'(a);

    // Reset state
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs", {26'd0, mem_req, run, busy, halted, timeout_err, 1'b0}, 32'd0);
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'd0);
    check("rst_count", {16'd0, instr_count}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two instructions then HALT
    mem[0] = 16'h2400; mem[1] = 16'h2401; mem[2] = 16'hFFFF;
    push_req(8'd0); push_exec(16'h2400, 8'd0);
    push_req(8'd1); push_exec(16'h2401, 8'd1);
    push_req(8'd2);
    pulse_start();
    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    check("t1_halted", {31'd0, halted}, 32'd1);
    check("t1_pc", {24'd0, pc}, 32'd2);
    check("t1_count", {16'd0, instr_count}, 32'd2);
    check("t1_instr", {16'd0, instr}, 32'h0000FFFF);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // Memory timeout
    mem_en = 1'b0;
    push_req(8'd0);
    pulse_start();
    wcnt = 0;
    for (int i = 0; i < 40 && !halted; i++) begin
      @(negedge clk);
      if (busy && !mem_req && !run) wcnt++;
    end
    check("t2_terr", {31'd0, timeout_err}, 32'd1);
    check("t2_halted", {31'd0, halted}, 32'd1);
    check("t2_wait_cycles", wcnt, 32'd15);
    mem_en = 1'b1;
    mem[0] = 16'hFFFF;
    push_req(8'd0);
    pulse_start();
    check("t2_terr_clr", {31'd0, timeout_err}, 32'd0);
    check("t2_req", {31'd0, mem_req}, 32'd1);
    for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
    check("t2_rehalt", {31'd0, halted}, 32'd1);
    check("t2_pc", {24'd0, pc}, 32'd0);

    // Stop during EXEC at pc=5
    for (int a = 0; a < 256; a++) mem[a] = 16'h2000 + 16'(a);
    for (int a = 0; a < 6; a++) begin
      push_req(8'(a)); push_exec(16'h2000 + 16'(a), 8'(a));
    end
    pulse_start();
    for (int i = 0; i < 300 && !(run && pc == 8'd5); i++) @(negedge clk);
    check("t3_reach_pc5", {31'd0, (run && pc == 8'd5)}, 32'd1);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    check("t3_pc", {24'd0, pc}, 32'd6);
    check("t3_count", {16'd0, instr_count}, 32'd6);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_halted", {31'd0, halted}, 32'd0);
    r0 = req_seen;
    repeat (10) @(negedge clk);
    check("t3_no_req", req_seen, r0);

    // start+stop together in IDLE; done in IDLE
    r0 = req_seen;
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_req", req_seen, r0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    done_force = 1'b1;
    repeat (2) @(negedge clk);
    done_force = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_pc", {24'd0, pc}, 32'd6);
    check("t6_count", {16'd0, instr_count}, 32'd6);

    // PC wrap from 8'hFF to 8'h00
    for (int a = 0; a < 256; a++) begin
      push_req(8'(a)); push_exec(16'h2000 + 16'(a), 8'(a));
    end
    push_req(8'd0);
    pulse_start();
    for (int i = 0; i < 3000 && !(run && pc == 8'hFF); i++) @(negedge clk);
    check("t4_reach_ff", {31'd0, (run && pc == 8'hFF)}, 32'd1);
    mem[0] = 16'hFFFF;
    for (int i = 0; i < 50 && !halted; i++) @(negedge clk);
    check("t4_halted", {31'd0, halted}, 32'd1);
    check("t4_pc", {24'd0, pc}, 32'd0);
    check("t4_addr", {24'd0, mem_addr}, 32'd0);
    check("t4_count", {16'd0, instr_count}, 32'd256);

    // Reset during WAIT with mem_valid in the same cycle
    mem[0] = 16'h2000;
    push_req(8'd0);
    pulse_start();
    @(negedge clk); #1;
    check("t5_setup", {30'd0, mem_valid, (busy && !mem_req && !run)}, 32'd3);
    reset = 1'b0;
    #1;
    check("t5_outs", {26'd0, mem_req, run, busy, halted, timeout_err, 1'b0}, 32'd0);
    check("t5_pc", {24'd0, pc}, 32'd0);
    check("t5_instr", {16'd0, instr}, 32'd0);
    check("t5_count", {16'd0, instr_count}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    r0 = req_seen;
    repeat (10) @(negedge clk);
    check("t5_no_req", req_seen, r0);
    check("t5_idle", {30'd0, busy, halted}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
